// File: rtl/alu_arb_pkg.sv
// Shared types and ALU op codes for the ALU arbiter, its round-robin helper and the ALU decode.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic owner_t;

  // Op codes as understood by the shared ALU; the arbiter passes them through undecoded.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_AND = 4'b1100;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright; on a tie the side that did
// not win last time gets the grant. Output is one-hot or zero.
import alu_arb_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (m0) and the address/PC unit (m1),
// one operation in flight, results returned over a per-requester valid/ready response.
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int W       = 32,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req_valid,
  output logic           m0_req_ready,
  input  logic [W-1:0]   m0_a,
  input  logic [W-1:0]   m0_b,
  input  logic [OPW-1:0] m0_op,
  output logic           m0_resp_valid,
  input  logic           m0_resp_ready,
  output logic [W-1:0]   m0_c,
  output logic           m0_z,
  input  logic           m1_req_valid,
  output logic           m1_req_ready,
  input  logic [W-1:0]   m1_a,
  input  logic [W-1:0]   m1_b,
  input  logic [OPW-1:0] m1_op,
  output logic           m1_resp_valid,
  input  logic           m1_resp_ready,
  output logic [W-1:0]   m1_c,
  output logic           m1_z,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_c,
  input  logic           alu_z
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t       state, state_nxt;
  owner_t       owner, last_grant, acc_id;
  logic [3:0]   cnt;
  logic [W-1:0] result;
  logic         zf;
  logic [1:0]   gnt;
  logic         accept, resp_ack;

  rr_arb2 u_rr (
    .req        ({m1_req_valid, m0_req_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign m0_req_ready = (state == IDLE) && gnt[0];
  assign m1_req_ready = (state == IDLE) && gnt[1];
  assign accept       = (m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready);
  assign acc_id       = gnt[1];
  // The non-owner's resp_ready must not retire someone else's result.
  assign resp_ack     = owner ? m1_resp_ready : m0_resp_ready;

  assign m0_resp_valid = (state == RESP) && !owner;
  assign m1_resp_valid = (state == RESP) && owner;
  assign m0_c = result;
  assign m1_c = result;
  assign m0_z = zf;
  assign m1_z = zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0)  state_nxt = RESP;
      RESP:    if (resp_ack)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // ALU operand registers stay loaded after capture so the ALU outputs do not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      result     <= '0;
      zf         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_a      <= acc_id ? m1_a  : m0_a;
          alu_b      <= acc_id ? m1_b  : m0_b;
          alu_op     <= acc_id ? m1_op : m0_op;
          owner      <= acc_id;
          last_grant <= acc_id;
          cnt        <= CNT_INIT;
        end
        EXEC: if (cnt == 4'd0) begin
          result <= alu_c;
          zf     <= alu_z;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
